// File: rtl/peridot_csr_swi_mbox.sv
// PERIDOT host-bridge CSR: ID/timecode, keyed CPU reset, LEDs, SWI pending/mask, mutex and
// an optional host<->CPU message FIFO built when PERIDOT_SWI_MBOX_FIFO_EN is defined.
module peridot_csr_swi_mbox #(
  parameter logic [31:0] CLASSID         = 32'h72A00000,
  parameter logic [31:0] TIMECODE        = 32'd1234567890,
  parameter logic [15:0] CPURESET_KEY    = 16'hdead,
  parameter int          CPURESET_INIT   = 0,
  parameter int          SWI_CHANNELS    = 8,
  parameter int          LED_WIDTH       = 4,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset,
  input  logic [3:0]              avs_address,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic                    ins_irq,
  output logic                    coe_cpureset,
  output logic [LED_WIDTH-1:0]    coe_led,
  input  logic [SWI_CHANNELS-1:0] coe_swi_in
);

  localparam logic RST_INIT = ((CPURESET_INIT & 1) != 0);

  logic wr_ctrl, wr_pend, wr_clr, wr_mask, wr_mutex;
  logic key_ok;

  assign wr_ctrl  = avs_write && (avs_address == 4'd2);
  assign wr_pend  = avs_write && (avs_address == 4'd3);
  assign wr_clr   = avs_write && (avs_address == 4'd4);
  assign wr_mask  = avs_write && (avs_address == 4'd5);
  assign wr_mutex = avs_write && (avs_address == 4'd6);
  assign key_ok   = (CPURESET_KEY == 16'h0) || (avs_writedata[31:16] == CPURESET_KEY);

  // Mutex: only a free lock or its current owner may write; owner 0 is never accepted,
  // and the owner writing value 0 releases the lock entirely.
  function automatic logic [31:0] mutex_next(input logic [31:0] cur, input logic [31:0] wd);
    logic [15:0] cur_owner;
    logic [15:0] wr_owner;
    cur_owner  = cur[31:16];
    wr_owner   = wd[31:16];
    mutex_next = cur;
    if ((wr_owner != 16'h0) && ((cur_owner == 16'h0) || (cur_owner == wr_owner))) begin
      if ((wd[15:0] == 16'h0) && (cur_owner == wr_owner))
        mutex_next = '0;
      else
        mutex_next = wd;
    end
  endfunction

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      coe_cpureset <= RST_INIT;
      coe_led      <= '0;
    end else if (wr_ctrl) begin
      coe_led <= avs_writedata[LED_WIDTH-1:0];
      if (key_ok)
        coe_cpureset <= avs_writedata[8];
    end
  end

  logic [SWI_CHANNELS-1:0] pending, mask, swi_in_p0;
  logic [SWI_CHANNELS-1:0] swi_rise, set_bits, clr_bits;
  logic [31:0]             mutex;

  assign swi_rise = coe_swi_in & ~swi_in_p0;
  assign set_bits = wr_pend ? avs_writedata[SWI_CHANNELS-1:0] : '0;
  assign clr_bits = wr_clr  ? avs_writedata[SWI_CHANNELS-1:0] : '0;

  // Edge set is applied after the W1C so a coincident edge survives the clear.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      swi_in_p0 <= '0;
      pending   <= '0;
      mask      <= '0;
      mutex     <= '0;
    end else begin
      swi_in_p0 <= coe_swi_in;
      pending   <= ((pending | set_bits) & ~clr_bits) | swi_rise;
      if (wr_mask)
        mask <= avs_writedata[SWI_CHANNELS-1:0];
      if (wr_mutex)
        mutex <= mutex_next(mutex, avs_writedata);
    end
  end

  logic [31:0] fifo_head;
  logic [31:0] fifo_status;
  logic        fifo_irq;

`ifdef PERIDOT_SWI_MBOX_FIFO_EN
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
  logic [8:0]  cnt_field;
  logic        fifo_push, fifo_pop, wr_stat;
  logic        fifo_empty, fifo_full;
  logic        ovf, unf, fifo_irq_en;
  logic [7:0]  fifo_thr;

  assign fifo_push  = avs_write && (avs_address == 4'd7);
  assign fifo_pop   = avs_read  && (avs_address == 4'd7);
  assign wr_stat    = avs_write && (avs_address == 4'd8);
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign cnt_field  = 9'(fifo_cnt);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Storage has no reset; stale words are unreachable while the pointers say empty.
  always_ff @(posedge csi_clk) begin
    if (fifo_push && !fifo_full)
      fifo_mem[wr_ptr[AW-1:0]] <= avs_writedata;
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      fifo_irq_en <= 1'b0;
      fifo_thr    <= '0;
    end else begin
      if (fifo_push) begin
        if (fifo_full)
          ovf <= 1'b1;
        else
          wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fifo_pop) begin
        if (fifo_empty)
          unf <= 1'b1;
        else
          rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_stat) begin
        if (avs_writedata[29])
          ovf <= 1'b0;
        if (avs_writedata[28])
          unf <= 1'b0;
        fifo_irq_en <= avs_writedata[24];
        fifo_thr    <= avs_writedata[23:16];
      end
    end
  end

  assign fifo_head   = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[AW-1:0]];
  assign fifo_status = {fifo_empty, fifo_full, ovf, unf, 3'b000, fifo_irq_en, fifo_thr,
                        7'b0, cnt_field};
  assign fifo_irq    = fifo_irq_en && ({1'b0, fifo_thr} <= cnt_field) && !fifo_empty;
`else
  logic unused_fifo_read;
  assign unused_fifo_read = avs_read;
  assign fifo_head        = 32'h0;
  assign fifo_status      = 32'h0;
  assign fifo_irq         = 1'b0;
`endif

  assign ins_irq = (|(pending & mask)) | fifo_irq;

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      4'd0: avs_readdata = CLASSID;
      4'd1: avs_readdata = TIMECODE;
      4'd2: begin
        avs_readdata[8]             = coe_cpureset;
        avs_readdata[LED_WIDTH-1:0] = coe_led;
      end
      4'd3: avs_readdata[SWI_CHANNELS-1:0] = pending;
      4'd4: avs_readdata[SWI_CHANNELS-1:0] = pending & mask;
      4'd5: avs_readdata[SWI_CHANNELS-1:0] = mask;
      4'd6: avs_readdata = mutex;
      4'd7: avs_readdata = fifo_head;
      4'd8: avs_readdata = fifo_status;
      default: avs_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_peridot_csr_swi_mbox.sv
// Bench for peridot_csr_swi_mbox (default parameters); FIFO checks follow PERIDOT_SWI_MBOX_FIFO_EN.
module tb_peridot_csr_swi_mbox;

  logic        csi_clk = 1'b0;
  logic        rsi_reset = 1'b0;
  logic [3:0]  avs_address = 4'h0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic        ins_irq;
  logic        coe_cpureset;
  logic [3:0]  coe_led;
  logic [7:0]  coe_swi_in = 8'h0;

  always #5 csi_clk = ~csi_clk;

  peridot_csr_swi_mbox dut (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset), .avs_address(avs_address),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .ins_irq(ins_irq), .coe_cpureset(coe_cpureset),
    .coe_led(coe_led), .coe_swi_in(coe_swi_in)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] cur_swi = 8'h0;

  // Reference model state
  logic [7:0]  m_pend, m_mask, m_prev;
  logic [3:0]  m_led;
  logic        m_rst;
  logic [15:0] m_owner, m_value;
  logic [31:0] m_q[$];
  logic        m_ovf, m_unf, m_en;
  logic [7:0]  m_thr;

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_led = 0; m_rst = 0;
    m_owner = 0; m_value = 0; m_q.delete();
    m_ovf = 0; m_unf = 0; m_en = 0; m_thr = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return 32'h72A00000;
      4'd1: return 32'd1234567890;
      4'd2: return {23'b0, m_rst, 4'b0, m_led};
      4'd3: return {24'b0, m_pend};
      4'd4: return {24'b0, m_pend & m_mask};
      4'd5: return {24'b0, m_mask};
      4'd6: return {m_owner, m_value};
`ifdef PERIDOT_SWI_MBOX_FIFO_EN
      4'd7: return (m_q.size() == 0) ? 32'h0 : m_q[0];
      4'd8: return {m_q.size() == 0, m_q.size() == 16, m_ovf, m_unf, 3'b0, m_en, m_thr,
                    7'b0, 9'(m_q.size())};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
    logic f;
    f = 1'b0;
`ifdef PERIDOT_SWI_MBOX_FIFO_EN
    f = m_en && (m_q.size() >= int'(m_thr)) && (m_q.size() != 0);
`endif
    return (|(m_pend & m_mask)) || f;
  endfunction

  task automatic model_step(input logic wr, input logic rd, input logic [3:0] a,
                            input logic [31:0] d, input logic [7:0] swi);
    logic [7:0] rise;
    rise = swi & ~m_prev;
    if (wr) begin
      case (a)
        4'd2: begin
          m_led = d[3:0];
          if (d[31:16] == 16'hdead) m_rst = d[8];
        end
        4'd3: m_pend = m_pend | d[7:0];
        4'd4: m_pend = m_pend & ~d[7:0];
        4'd5: m_mask = d[7:0];
        4'd6: begin
          if (d[31:16] != 0 && (m_owner == 0 || m_owner == d[31:16])) begin
            if (d[15:0] == 0 && m_owner == d[31:16]) begin
              m_owner = 0; m_value = 0;
            end else begin
              m_owner = d[31:16]; m_value = d[15:0];
            end
          end
        end
`ifdef PERIDOT_SWI_MBOX_FIFO_EN
        4'd7: if (m_q.size() < 16) m_q.push_back(d); else m_ovf = 1;
        4'd8: begin
          if (d[29]) m_ovf = 0;
          if (d[28]) m_unf = 0;
          m_en = d[24]; m_thr = d[23:16];
        end
`endif
        default: ;
      endcase
    end
`ifdef PERIDOT_SWI_MBOX_FIFO_EN
    if (rd && a == 4'd7) begin
      if (m_q.size() == 0) m_unf = 1;
      else void'(m_q.pop_front());
    end
`endif
    m_pend = m_pend | rise;
    m_prev = swi;
  endtask

  // One bus cycle: drive at negedge, sample read data before the edge, update model after it.
  task automatic cycle(input logic wr, input logic rd, input logic [3:0] a,
                       input logic [31:0] d, input logic [7:0] swi, output logic [31:0] got);
    @(negedge csi_clk);
    avs_write = wr; avs_read = rd; avs_address = a; avs_writedata = d; coe_swi_in = swi;
    #1 got = avs_readdata;
    @(posedge csi_clk);
    #1;
    avs_write = 1'b0; avs_read = 1'b0;
    model_step(wr, rd, a, d, swi);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    cycle(1'b1, 1'b0, a, d, cur_swi, dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] got);
    cycle(1'b0, 1'b1, a, 32'h0, cur_swi, got);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    cur_swi = 0; coe_swi_in = 0;
    rsi_reset = 1'b1;
    model_reset();
    @(negedge csi_clk);
    n_cmp++;
    if (coe_cpureset !== 1'b0 || coe_led !== 4'h0 || ins_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rst=%b led=%h irq=%b expected 0 0 0", coe_cpureset, coe_led, ins_irq);
    end
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    for (int a = 0; a < 9; a++) begin
      exp = model_read(4'(a));
      rd(4'(a), got);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, got, exp);
      end
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] got;
    wr(4'd2, 32'h0000_0105);
    n_cmp++;
    if (coe_led !== 4'h5 || coe_cpureset !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_wrong_key: led=%h rst=%b expected led=5 rst=0", coe_led, coe_cpureset);
    end
    wr(4'd2, 32'hDEAD_0100);
    n_cmp++;
    if (coe_led !== 4'h0 || coe_cpureset !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_key: led=%h rst=%b expected led=0 rst=1", coe_led, coe_cpureset);
    end
    rd(4'd2, got);
    n_cmp++;
    if (got !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL ctrl_read: got %h expected 00000100", got);
    end
  endtask

  task automatic test_swi_irq();
    logic [31:0] got;
    wr(4'd5, 32'h0F);
    wr(4'd3, 32'h30);
    n_cmp++;
    if (ins_irq !== 1'b0) begin n_fail++; $display("FAIL swi_masked: irq=%b expected 0", ins_irq); end
    wr(4'd3, 32'h01);
    n_cmp++;
    if (ins_irq !== 1'b1) begin n_fail++; $display("FAIL swi_unmasked: irq=%b expected 1", ins_irq); end
    rd(4'd4, got);
    n_cmp++;
    if (got !== 32'h01) begin n_fail++; $display("FAIL swi_masked_read: got %h expected 00000001", got); end
    wr(4'd4, 32'h01);
    n_cmp++;
    if (ins_irq !== 1'b0) begin n_fail++; $display("FAIL swi_w1c: irq=%b expected 0", ins_irq); end
    rd(4'd3, got);
    n_cmp++;
    if (got !== 32'h30) begin n_fail++; $display("FAIL swi_pending: got %h expected 00000030", got); end
  endtask

  task automatic test_edge_vs_clear();
    logic [31:0] got, dummy;
    wr(4'd3, 32'h04);
    cur_swi = 8'h04;
    cycle(1'b1, 1'b0, 4'd4, 32'h04, cur_swi, dummy);
    rd(4'd3, got);
    n_cmp++;
    if (got !== 32'h34) begin n_fail++; $display("FAIL edge_beats_clear: got %h expected 00000034", got); end
    wr(4'd4, 32'h04);
    rd(4'd3, got);
    n_cmp++;
    if (got !== 32'h30) begin n_fail++; $display("FAIL level_no_retrigger: got %h expected 00000030", got); end
    cur_swi = 8'h00; wr(4'd0, 32'h0);
    cur_swi = 8'h04; wr(4'd0, 32'h0);
    rd(4'd3, got);
    n_cmp++;
    if (got !== 32'h34) begin n_fail++; $display("FAIL second_edge: got %h expected 00000034", got); end
    cur_swi = 8'h00;
    wr(4'd4, 32'hFF);
  endtask

  task automatic test_mutex();
    logic [31:0] got;
    logic [31:0] wd  [5] = '{32'h0001_00AA, 32'h0002_00BB, 32'h0000_1234, 32'h0001_0000, 32'h0002_00BB};
    logic [31:0] exp [5] = '{32'h0001_00AA, 32'h0001_00AA, 32'h0001_00AA, 32'h0000_0000, 32'h0002_00BB};
    for (int i = 0; i < 5; i++) begin
      wr(4'd6, wd[i]);
      rd(4'd6, got);
      n_cmp++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL mutex_step%0d: got %h expected %h", i, got, exp[i]);
      end
    end
    wr(4'd6, 32'h0002_0000);
  endtask

  task automatic test_fifo();
    logic [31:0] got;
`ifdef PERIDOT_SWI_MBOX_FIFO_EN
    for (int i = 1; i <= 17; i++) wr(4'd7, 32'(i));
    rd(4'd8, got);
    n_cmp++;
    if (got !== 32'h6000_0010) begin n_fail++; $display("FAIL fifo_full_status: got %h expected 60000010", got); end
    for (int i = 1; i <= 16; i++) begin
      rd(4'd7, got);
      n_cmp++;
      if (got !== 32'(i)) begin n_fail++; $display("FAIL fifo_pop%0d: got %h expected %h", i, got, 32'(i)); end
    end
    rd(4'd8, got);
    n_cmp++;
    if (got !== 32'hA000_0000) begin n_fail++; $display("FAIL fifo_empty_status: got %h expected a0000000", got); end
    rd(4'd7, got);
    n_cmp++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL fifo_underflow_data: got %h expected 00000000", got); end
    rd(4'd8, got);
    n_cmp++;
    if (got !== 32'hB000_0000) begin n_fail++; $display("FAIL fifo_underflow_status: got %h expected b0000000", got); end
    wr(4'd8, 32'h3000_0000);
    rd(4'd8, got);
    n_cmp++;
    if (got !== 32'h8000_0000) begin n_fail++; $display("FAIL fifo_sticky_w1c: got %h expected 80000000", got); end
`else
    wr(4'd7, 32'h1234_5678);
    wr(4'd8, 32'hFFFF_FFFF);
    rd(4'd7, got);
    n_cmp++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL nofifo_reg7: got %h expected 00000000", got); end
    rd(4'd8, got);
    n_cmp++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL nofifo_reg8: got %h expected 00000000", got); end
`endif
  endtask

  task automatic test_fifo_irq();
    logic [31:0] got;
    logic        exp_irq [3] = '{1'b0, 1'b1, 1'b0};
    wr(4'd4, 32'hFF);
    wr(4'd8, 32'h0103_0000);
    wr(4'd7, 32'hA1);
    wr(4'd7, 32'hA2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) wr(4'd7, 32'hA3);
      if (i == 2) rd(4'd7, got);
`ifndef PERIDOT_SWI_MBOX_FIFO_EN
      exp_irq[i] = 1'b0;
`endif
      n_cmp++;
      if (ins_irq !== exp_irq[i]) begin
        n_fail++;
        $display("FAIL fifo_irq_step%0d: irq=%b expected %b", i, ins_irq, exp_irq[i]);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] got, exp;
    for (int a = 9; a < 16; a++) begin
      wr(4'(a), $urandom);
      rd(4'(a), got);
      n_cmp++;
      if (got !== 32'h0) begin n_fail++; $display("FAIL unmapped_reg%0d: got %h expected 00000000", a, got); end
    end
    for (int a = 2; a < 9; a++) begin
      exp = model_read(4'(a));
      rd(4'(a), got);
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL unmapped_side_reg%0d: got %h expected %h", a, got, exp); end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] got, exp;
    wr(4'd2, 32'hDEAD_0107);
    wr(4'd3, 32'hFF);
    wr(4'd7, 32'h55);
    @(negedge csi_clk);
    avs_write = 1'b1; avs_address = 4'd7; avs_writedata = 32'h66;
    #2 rsi_reset = 1'b1;
    #1;
    n_cmp++;
    if (ins_irq !== 1'b0 || coe_led !== 4'h0 || coe_cpureset !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: irq=%b led=%h rst=%b expected 0 0 0", ins_irq, coe_led, coe_cpureset);
    end
    @(posedge csi_clk);
    #1 avs_write = 1'b0;
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    model_reset();
    for (int a = 2; a < 9; a++) begin
      exp = model_read(4'(a));
      rd(4'(a), got);
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL mid_reset_reg%0d: got %h expected %h", a, got, exp); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  a;
      logic [31:0] d, exp, got;
      int          op;
      a = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) a = 4'($urandom_range(10, 15));
      d = $urandom;
      if (a == 4'd2 && $urandom_range(0, 1) == 1) d[31:16] = 16'hdead;
      if (a == 4'd6) d[31:16] = 16'($urandom_range(0, 3));
      if (a == 4'd6 && $urandom_range(0, 3) == 0) d[15:0] = 16'h0;
      if (a == 4'd8) d[23:16] = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) cur_swi = 8'($urandom);
      op  = $urandom_range(0, 2);
      exp = model_read(a);
      cycle(op == 1, op == 2, a, d, cur_swi, got);
      n_cmp++;
      if (op == 2 && got !== exp) begin
        n_fail++;
        $display("FAIL rand_read%0d reg%0d: got %h expected %h", i, a, got, exp);
      end
      n_cmp++;
      if (ins_irq !== model_irq() || coe_led !== m_led || coe_cpureset !== m_rst) begin
        n_fail++;
        $display("FAIL rand_outputs%0d: irq=%b led=%h rst=%b expected %b %h %b",
                 i, ins_irq, coe_led, coe_cpureset, model_irq(), m_led, m_rst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_swi_irq();
    test_edge_vs_clear();
    test_mutex();
    test_fifo();
    test_fifo_irq();
    test_unmapped();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
